vga_pixel_sink: RTL and testbench

//  Receiving end of the vga_x/vga_y/vga_colour/vga_plot plot interface that the drawing

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_pixel_sink_fb_ram.sv | 27 ++
 rtl/vga_pixel_sink.sv | 189 ++++++++++++++++++
 tb/tb_vga_pixel_sink.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and geometry for the 160x120 plot framebuffer.
package vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int CBITS    = 3;
   localparam int FB_DEPTH = SCREEN_W * SCREEN_H;

   typedef logic [7:0]       xcoord_t;
   typedef logic [6:0]       ycoord_t;
   typedef logic [CBITS-1:0] colour_t;
   typedef logic [14:0]      fb_addr_t;

   typedef enum logic {C_IDLE, C_FILL} clear_state_t;
   typedef enum logic {S_IDLE, S_RUN}  scan_state_t;

   // Linear framebuffer address, row-major with x fastest.
   function automatic fb_addr_t fb_addr(input xcoord_t x, input ycoord_t y);
      return fb_addr_t'(y) * fb_addr_t'(SCREEN_W) + fb_addr_t'(x);
   endfunction

endpackage

// File: rtl/vga_pixel_sink_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
module fb_ram
   import vga_pkg::*;
(
   input  logic                clk,
   input  logic                i_we,
   input  logic [14:0]         i_waddr,
   input  logic [CBITS-1:0]    i_wdata,
   input  logic                i_re,
   input  logic [14:0]         i_raddr,
   output logic [CBITS-1:0]    o_rdata
);

   // NOTE: the storage array has no reset so it can map onto block RAM.
   colour_t r_mem [FB_DEPTH];
   colour_t r_rdata;

   // Write and read in one clocked process; the read holds its value when not enabled.
   // NOTE: nonblocking assignments make a same-address read return the pre-write contents.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_pixel_sink.sv
// Plot-interface framebuffer with bulk clear and valid/ready raster readout.
module vga_pixel_sink
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       vga_x,
   input  logic [6:0]       vga_y,
   input  logic [CBITS-1:0] vga_colour,
   input  logic             vga_plot,
   input  logic             clear_start,
   input  logic [CBITS-1:0] clear_colour,
   output logic             clear_busy,
   input  logic             scan_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_x,
   output logic [6:0]       out_y,
   output logic [CBITS-1:0] out_colour,
   output logic             out_sof,
   output logic             out_eol
);

   clear_state_t r_clr_state, w_clr_state_nxt;
   fb_addr_t     r_clr_addr, w_clr_addr_nxt;
   colour_t      r_clr_colour, w_clr_colour_nxt;

   scan_state_t  r_scan_state, w_scan_state_nxt;
   xcoord_t      r_scan_x, w_scan_x_nxt;
   ycoord_t      r_scan_y, w_scan_y_nxt;

   logic         r_p1_valid;
   xcoord_t      r_p1_x;
   ycoord_t      r_p1_y;

   logic         r_out_valid, r_out_sof, r_out_eol;
   xcoord_t      r_out_x;
   ycoord_t      r_out_y;
   colour_t      r_out_colour;

   logic         w_we, w_issue, w_load_out, w_p1_free, w_x_last, w_y_last;
   fb_addr_t     w_waddr, w_raddr;
   colour_t      w_wdata, w_rdata;

   // Clear FSM next state: walk every address once with the latched colour.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_clr_state_nxt  = r_clr_state;
      w_clr_addr_nxt   = r_clr_addr;
      w_clr_colour_nxt = r_clr_colour;
      case (r_clr_state)
         C_IDLE: begin
            if (clear_start) begin
               w_clr_state_nxt  = C_FILL;
               w_clr_addr_nxt   = '0;
               w_clr_colour_nxt = clear_colour;
            end
         end
         C_FILL: begin
            if (r_clr_addr == fb_addr_t'(FB_DEPTH - 1)) w_clr_state_nxt = C_IDLE;
            else                                         w_clr_addr_nxt  = r_clr_addr + 1'b1;
         end
         default: w_clr_state_nxt = C_IDLE;
      endcase
   end

   // Clear FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clr_state  <= C_IDLE;
         r_clr_addr   <= '0;
         r_clr_colour <= '0;
      end else begin
         r_clr_state  <= w_clr_state_nxt;
         r_clr_addr   <= w_clr_addr_nxt;
         r_clr_colour <= w_clr_colour_nxt;
      end
   end

   assign clear_busy = (r_clr_state == C_FILL);

   // Write-port mux: the clear owns the port while filling, otherwise in-range plots.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = fb_addr(vga_x, vga_y);
      w_wdata = vga_colour;
      if (r_clr_state == C_FILL) begin
         w_we    = 1'b1;
         w_waddr = r_clr_addr;
         w_wdata = r_clr_colour;
      end else if (vga_plot && vga_x < xcoord_t'(SCREEN_W) && vga_y < ycoord_t'(SCREEN_H)) begin
         w_we = 1'b1;
      end
   end

   // Readout pipeline handshake: output register loads when empty or being drained,
   // the RAM stage advances when it is empty or feeding the output.
   assign w_load_out = r_p1_valid && (!r_out_valid || out_ready);
   assign w_p1_free  = !r_p1_valid || w_load_out;
   assign w_issue    = (r_scan_state == S_RUN) && w_p1_free;
   assign w_x_last   = (r_scan_x == xcoord_t'(SCREEN_W - 1));
   assign w_y_last   = (r_scan_y == ycoord_t'(SCREEN_H - 1));
   assign w_raddr    = fb_addr(r_scan_x, r_scan_y);

   // Scan FSM next state and raster position; a frame always runs to its last pixel.
   always_comb begin
      w_scan_state_nxt = r_scan_state;
      w_scan_x_nxt     = r_scan_x;
      w_scan_y_nxt     = r_scan_y;
      case (r_scan_state)
         S_IDLE:  if (scan_en) w_scan_state_nxt = S_RUN;
         S_RUN:   if (w_issue && w_x_last && w_y_last && !scan_en) w_scan_state_nxt = S_IDLE;
         default: w_scan_state_nxt = S_IDLE;
      endcase
      if (w_issue) begin
         if (w_x_last) begin
            w_scan_x_nxt = '0;
            w_scan_y_nxt = w_y_last ? '0 : r_scan_y + 1'b1;
         end else begin
            w_scan_x_nxt = r_scan_x + 1'b1;
         end
      end
   end

   // Scan FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_state <= S_IDLE;
         r_scan_x     <= '0;
         r_scan_y     <= '0;
      end else begin
         r_scan_state <= w_scan_state_nxt;
         r_scan_x     <= w_scan_x_nxt;
         r_scan_y     <= w_scan_y_nxt;
      end
   end

   // RAM stage: coordinates travelling alongside the read issued last cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p1_valid <= 1'b0;
         r_p1_x     <= '0;
         r_p1_y     <= '0;
      end else if (w_p1_free) begin
         r_p1_valid <= w_issue;
         r_p1_x     <= r_scan_x;
         r_p1_y     <= r_scan_y;
      end
   end

   // Output register: holds the pixel steady while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_x      <= '0;
         r_out_y      <= '0;
         r_out_colour <= '0;
         r_out_sof    <= 1'b0;
         r_out_eol    <= 1'b0;
      end else if (w_load_out) begin
         r_out_valid  <= 1'b1;
         r_out_x      <= r_p1_x;
         r_out_y      <= r_p1_y;
         r_out_colour <= w_rdata;
         r_out_sof    <= (r_p1_x == '0) && (r_p1_y == '0);
         r_out_eol    <= (r_p1_x == xcoord_t'(SCREEN_W - 1));
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_x      = r_out_x;
   assign out_y      = r_out_y;
   assign out_colour = r_out_colour;
   assign out_sof    = r_out_sof;
   assign out_eol    = r_out_eol;

   fb_ram u_fb_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_issue),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed bench for vga_pixel_sink with a reference framebuffer model.
module tb_vga_pixel_sink;
   import vga_pkg::*;

   logic          clk;
   logic          rst;
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   colour_t       vga_colour;
   logic          vga_plot;
   logic          clear_start;
   colour_t       clear_colour;
   logic          clear_busy;
   logic          scan_en;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_x;
   logic [6:0]    out_y;
   colour_t       out_colour;
   logic          out_sof;
   logic          out_eol;

   int            errors = 0;
   int            checks = 0;
   colour_t       model [FB_DEPTH];

   typedef struct {int x; int y; int c;} plot_vec_t;
   plot_vec_t     plots [4] = '{'{0, 0, 1}, '{159, 119, 7}, '{80, 60, 4}, '{160, 5, 2}};

   localparam int COLL_IDX = 31 * 160 + 20;

   vga_pixel_sink dut (
      .clk          (clk),
      .rst          (rst),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot),
      .clear_start  (clear_start),
      .clear_colour (clear_colour),
      .clear_busy   (clear_busy),
      .scan_en      (scan_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_x        (out_x),
      .out_y        (out_y),
      .out_colour   (out_colour),
      .out_sof      (out_sof),
      .out_eol      (out_eol)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scan one frame (or its first n_pix pixels) and compare against the model.
   task automatic capture(input string tag, input int n_pix, input int rand_until,
                          input int drop_idx, input int coll_idx, input colour_t coll_col);
      int lat, got, cyc, ex, ey, e_pos, e_col, e_flag, e_stall, n_sof, n_eol, first_bad, drain;
      bit h_stall;
      logic [7:0] h_x;
      logic [6:0] h_y;
      colour_t h_c;
      logic h_sof, h_eol;
      lat = 0; got = 0; cyc = 0; e_pos = 0; e_col = 0; e_flag = 0; e_stall = 0;
      n_sof = 0; n_eol = 0; first_bad = -1; drain = 0; h_stall = 1'b0;
      h_x = '0; h_y = '0; h_c = '0; h_sof = 1'b0; h_eol = 1'b0;
      out_ready = 1'b1;
      scan_en   = 1'b1;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL %s first_valid_latency: got %0d cycles, want 3", tag, lat);
      end
      while (got < n_pix && cyc < 3 * n_pix + 200) begin
         vga_plot = 1'b0;
         if (h_stall && (!out_valid || out_x !== h_x || out_y !== h_y || out_colour !== h_c ||
                         out_sof !== h_sof || out_eol !== h_eol))
            e_stall++;
         out_ready = (got < rand_until) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            ex = got % SCREEN_W;
            ey = got / SCREEN_W;
            if (out_x !== 8'(ex) || out_y !== 7'(ey)) e_pos++;
            if (out_colour !== model[got]) begin
               if (e_col == 0) first_bad = got;
               e_col++;
            end
            if (out_sof !== (got == 0) || out_eol !== (ex == SCREEN_W - 1)) e_flag++;
            n_sof += int'(out_sof);
            n_eol += int'(out_eol);
            if (got == drop_idx) scan_en = 1'b0;
            if (got == coll_idx - 2) begin
               vga_plot   = 1'b1;
               vga_x      = 8'(coll_idx % SCREEN_W);
               vga_y      = 7'(coll_idx / SCREEN_W);
               vga_colour = coll_col;
            end
            got++;
         end
         h_stall = out_valid && !out_ready;
         h_x = out_x; h_y = out_y; h_c = out_colour; h_sof = out_sof; h_eol = out_eol;
         @(negedge clk);
         cyc++;
      end
      vga_plot  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != n_pix) begin
         errors++;
         $display("FAIL %s transfers: got %0d, want %0d", tag, got, n_pix);
      end
      checks++;
      if (e_pos != 0) begin
         errors++;
         $display("FAIL %s raster_order: %0d pixels at wrong x/y, want 0", tag, e_pos);
      end
      checks++;
      if (e_col != 0) begin
         errors++;
         $display("FAIL %s colour: %0d wrong pixels (first idx %0d), want 0", tag, e_col, first_bad);
      end
      checks++;
      if (e_flag != 0) begin
         errors++;
         $display("FAIL %s sof_eol_flags: %0d wrong, want 0", tag, e_flag);
      end
      checks++;
      if (e_stall != 0) begin
         errors++;
         $display("FAIL %s stall_stability: %0d changes under stall, want 0", tag, e_stall);
      end
      if (n_pix == FB_DEPTH) begin
         checks++;
         if (n_sof != 1) begin
            errors++;
            $display("FAIL %s sof_count: got %0d, want 1", tag, n_sof);
         end
         checks++;
         if (n_eol != SCREEN_H) begin
            errors++;
            $display("FAIL %s eol_count: got %0d, want %0d", tag, n_eol, SCREEN_H);
         end
         for (int i = 0; i < 9; i++) begin
            if (out_valid !== 1'b0) drain++;
            @(negedge clk);
         end
         checks++;
         if (drain != 0) begin
            errors++;
            $display("FAIL %s stop_after_frame: out_valid high %0d cycles, want 0", tag, drain);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
      clear_start = 1'b0; clear_colour = '0; scan_en = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, clear_busy, out_sof, out_eol} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b, want 0000", {out_valid, clear_busy, out_sof, out_eol});
      end
      checks++;
      if (out_x !== 8'd0 || out_y !== 7'd0) begin
         errors++;
         $display("FAIL reset_xy: got (%0d,%0d), want (0,0)", out_x, out_y);
      end
      checks++;
      if (out_colour !== 3'd0) begin
         errors++;
         $display("FAIL reset_colour: got %0d, want 0", out_colour);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || clear_busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: valid=%b busy=%b, want 0 0", out_valid, clear_busy);
      end
   endtask

   // Clear to colour 0 while plots stream in and a second clear_start arrives.
   task automatic test_clear_under_plots();
      int n;
      clear_colour = 3'd0;
      clear_start  = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      n = 0;
      while (clear_busy && n < FB_DEPTH + 100) begin
         n++;
         vga_plot     = (n >= 10 && n < 400);
         vga_x        = 8'(n % SCREEN_W);
         vga_y        = 7'((n / SCREEN_W) % SCREEN_H);
         vga_colour   = 3'((n % 4) + 1);
         clear_start  = (n == 5000);
         clear_colour = 3'd3;
         @(negedge clk);
      end
      vga_plot = 1'b0;
      clear_start = 1'b0;
      checks++;
      if (n != FB_DEPTH) begin
         errors++;
         $display("FAIL clear_busy_cycles: got %0d, want %0d", n, FB_DEPTH);
      end
      for (int i = 0; i < FB_DEPTH; i++) model[i] = 3'd0;
   endtask

   // Plot vectors, then scan with random back-pressure, a collision and a mid-frame scan_en drop.
   task automatic test_plot_and_stream();
      for (int i = 0; i < 4; i++) begin
         vga_plot   = 1'b1;
         vga_x      = 8'(plots[i].x);
         vga_y      = 7'(plots[i].y);
         vga_colour = 3'(plots[i].c);
         @(negedge clk);
         if (plots[i].x < SCREEN_W && plots[i].y < SCREEN_H)
            model[plots[i].y * SCREEN_W + plots[i].x] = 3'(plots[i].c);
      end
      vga_plot = 1'b0;
      capture("frame1", FB_DEPTH, 2000, 3 * SCREEN_W + 10, COLL_IDX, 3'd6);
      model[COLL_IDX] = 3'd6;
   endtask

   task automatic test_reset_mid_frame();
      capture("frame2", 300, 0, 1, -10, 3'd0);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midframe_valid: got %b, want 1", out_valid);
      end
      rst = 1'b1;
      scan_en = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_midframe_valid: got %b, want 0", out_valid);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_rescan();
      capture("frame3", FB_DEPTH, 0, 1, -10, 3'd0);
   endtask

   initial begin
      test_reset();
      test_clear_under_plots();
      test_plot_and_stream();
      test_reset_mid_frame();
      test_rescan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
